// File: rtl/write_bank_scheduler_if.sv
// Request/response bundle for write_bank_scheduler: a four-lane write group
// on the request side and four registered bank write ports on the other.
interface write_bank_scheduler_if #(
    parameter int ADDRW = 16,
    parameter int WL    = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       lane_vld;
    logic [ADDRW-1:0] lane_addr0;
    logic [ADDRW-1:0] lane_addr1;
    logic [ADDRW-1:0] lane_addr2;
    logic [ADDRW-1:0] lane_addr3;
    logic [WL-1:0]    lane_data0;
    logic [WL-1:0]    lane_data1;
    logic [WL-1:0]    lane_data2;
    logic [WL-1:0]    lane_data3;
    logic [3:0]       bank_we;
    logic [ADDRW-3:0] bank_addr0;
    logic [ADDRW-3:0] bank_addr1;
    logic [ADDRW-3:0] bank_addr2;
    logic [ADDRW-3:0] bank_addr3;
    logic [WL-1:0]    bank_data0;
    logic [WL-1:0]    bank_data1;
    logic [WL-1:0]    bank_data2;
    logic [WL-1:0]    bank_data3;
    logic             busy;

    modport master (
        output in_valid, lane_vld,
        output lane_addr0, lane_addr1, lane_addr2, lane_addr3,
        output lane_data0, lane_data1, lane_data2, lane_data3,
        input  in_ready, busy, bank_we,
        input  bank_addr0, bank_addr1, bank_addr2, bank_addr3,
        input  bank_data0, bank_data1, bank_data2, bank_data3
    );

    modport slave (
        input  in_valid, lane_vld,
        input  lane_addr0, lane_addr1, lane_addr2, lane_addr3,
        input  lane_data0, lane_data1, lane_data2, lane_data3,
        output in_ready, busy, bank_we,
        output bank_addr0, bank_addr1, bank_addr2, bank_addr3,
        output bank_data0, bank_data1, bank_data2, bank_data3
    );
endinterface

// File: rtl/write_bank_scheduler.sv
// Four-lane to four-bank write scheduler. Each cycle every bank takes the
// lowest-index outstanding lane that maps to it (address bits [1:0]); lanes
// that lose are parked in pending registers and issued in later rounds, so
// same-address writes land in ascending lane order.
// Optional: define WSCHED_STATS_EN to add the 16-bit saturating conflict_cnt
// output counting accepted groups that need two or more rounds.
module write_bank_scheduler #(
    parameter int ADDRW = 16,
    parameter int WL    = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    write_bank_scheduler_if.slave bus
`ifdef WSCHED_STATS_EN
    ,
    output logic [15:0] conflict_cnt
`endif
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [0:0]       state;
    logic [3:0]       pend_vld;
    logic [ADDRW-1:0] pend_addr [4];
    logic [WL-1:0]    pend_data [4];

    logic [ADDRW-1:0] lane_addr [4];
    logic [WL-1:0]    lane_data [4];

    logic             accept;
    logic [3:0]       src_vld;
    logic [ADDRW-1:0] src_addr [4];
    logic [WL-1:0]    src_data [4];
    logic [3:0]       hit;
    logic [1:0]       sel [4];
    logic [3:0]       grant;
    logic [3:0]       rem;

    logic [3:0]       we_q;
    logic [ADDRW-3:0] baddr_q [4];
    logic [WL-1:0]    bdata_q [4];

    assign lane_addr[0] = bus.lane_addr0;
    assign lane_addr[1] = bus.lane_addr1;
    assign lane_addr[2] = bus.lane_addr2;
    assign lane_addr[3] = bus.lane_addr3;
    assign lane_data[0] = bus.lane_data0;
    assign lane_data[1] = bus.lane_data1;
    assign lane_data[2] = bus.lane_data2;
    assign lane_data[3] = bus.lane_data3;

    assign accept = bus.in_valid && (state == IDLE) && ena;

    // Candidate lanes this cycle: the incoming group when idle, else pending.
    always_comb begin
        src_vld = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            src_addr[i] = lane_addr[i];
            src_data[i] = lane_data[i];
        end
        if (state == ISSUE) begin
            src_vld = pend_vld;
            for (int i = 0; i < 4; i++) begin
                src_addr[i] = pend_addr[i];
                src_data[i] = pend_data[i];
            end
        end else if (accept) begin
            src_vld = bus.lane_vld;
        end
    end

    // Per-bank pick of the lowest-index candidate; scan high-to-low so the
    // lowest matching lane is the last one written.
    always_comb begin
        hit   = 4'b0000;
        grant = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            sel[b] = 2'd0;
            for (int i = 3; i >= 0; i--) begin
                if (src_vld[i] && (src_addr[i][1:0] == 2'(b))) begin
                    hit[b] = 1'b1;
                    sel[b] = 2'(i);
                end
            end
        end
        for (int b = 0; b < 4; b++) begin
            if (hit[b]) begin
                grant[sel[b]] = 1'b1;
            end
        end
        rem = src_vld & ~grant;
    end

    // Control state, pending mask and registered bank ports; ena low freezes
    // everything except the write strobes, which drop to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend_vld <= 4'b0000;
            we_q     <= 4'b0000;
            for (int b = 0; b < 4; b++) begin
                baddr_q[b] <= '0;
                bdata_q[b] <= '0;
            end
        end else if (!ena) begin
            we_q <= 4'b0000;
        end else begin
            we_q <= hit;
            for (int b = 0; b < 4; b++) begin
                if (hit[b]) begin
                    baddr_q[b] <= src_addr[sel[b]][ADDRW-1:2];
                    bdata_q[b] <= src_data[sel[b]];
                end
            end
            if ((state == ISSUE) || accept) begin
                pend_vld <= rem;
                state    <= (|rem) ? ISSUE : IDLE;
            end
        end
    end

    // Pending address/data snapshot of an accepted group; validity lives in pend_vld.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                pend_addr[i] <= lane_addr[i];
                pend_data[i] <= lane_data[i];
            end
        end
    end

`ifdef WSCHED_STATS_EN
    logic [15:0] cnt_q;

    // Count accepted groups that leave lanes behind after round one, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'h0000;
        end else if (accept && (|rem) && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'h0001;
        end
    end

    assign conflict_cnt = cnt_q;
`endif

    assign bus.in_ready   = (state == IDLE);
    assign bus.busy       = (state == ISSUE);
    assign bus.bank_we    = we_q;
    assign bus.bank_addr0 = baddr_q[0];
    assign bus.bank_addr1 = baddr_q[1];
    assign bus.bank_addr2 = baddr_q[2];
    assign bus.bank_addr3 = baddr_q[3];
    assign bus.bank_data0 = bdata_q[0];
    assign bus.bank_data1 = bdata_q[1];
    assign bus.bank_data2 = bdata_q[2];
    assign bus.bank_data3 = bdata_q[3];
endmodule

// File: tb/tb_write_bank_scheduler.sv
// Self-checking bench for write_bank_scheduler: directed timing checks plus a
// scoreboard of expected per-cycle bank writes derived from each group.
module tb_write_bank_scheduler;
    localparam int ADDRW = 16;
    localparam int WL    = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b1;

    write_bank_scheduler_if #(.ADDRW(ADDRW), .WL(WL)) bus();

`ifdef WSCHED_STATS_EN
    logic [15:0] conflict_cnt;
    int          exp_cnt = 0;
`endif

    write_bank_scheduler #(.ADDRW(ADDRW), .WL(WL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
`ifdef WSCHED_STATS_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]                  we;
        logic [3:0][ADDRW-3:0]       addr;
        logic [3:0][WL-1:0]          data;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", tag, act, exp);
        end
    endtask

    function automatic logic [ADDRW-3:0] got_addr(input int b);
        case (b)
            0: return bus.bank_addr0;
            1: return bus.bank_addr1;
            2: return bus.bank_addr2;
            default: return bus.bank_addr3;
        endcase
    endfunction

    function automatic logic [WL-1:0] got_data(input int b);
        case (b)
            0: return bus.bank_data0;
            1: return bus.bank_data1;
            2: return bus.bank_data2;
            default: return bus.bank_data3;
        endcase
    endfunction

    // Scoreboard: every cycle with a write strobe must match the next expected beat.
    always @(negedge clk) begin
        if (rst_n && (bus.bank_we != 4'b0000)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_we", bus.bank_we, 64'h0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_we", bus.bank_we, mon_e.we);
                for (int b = 0; b < 4; b++) begin
                    if (mon_e.we[b]) begin
                        chk($sformatf("sb_addr%0d", b), got_addr(b), mon_e.addr[b]);
                        chk($sformatf("sb_data%0d", b), got_data(b), mon_e.data[b]);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a group, wait (bounded) for acceptance, then queue its expected rounds.
    // A lane's round is the number of lower-index valid lanes hitting the same bank.
    task automatic send(input logic [3:0] vld,
                        input logic [15:0] a0, input logic [15:0] a1,
                        input logic [15:0] a2, input logic [15:0] a3,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3);
        logic [15:0] a [4];
        logic [31:0] d [4];
        int          rnd [4];
        int          k;
        beat_t       bt;
        bit          acc;
        a = '{a0, a1, a2, a3};
        d = '{d0, d1, d2, d3};
        bus.in_valid   = 1'b1;
        bus.lane_vld   = vld;
        bus.lane_addr0 = a0;
        bus.lane_addr1 = a1;
        bus.lane_addr2 = a2;
        bus.lane_addr3 = a3;
        bus.lane_data0 = d0;
        bus.lane_data1 = d1;
        bus.lane_data2 = d2;
        bus.lane_data3 = d3;
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) begin
            acc = bus.in_ready && ena;
            step();
        end
        if (!acc) chk("accept_timeout", 64'h0, 64'h1);
        bus.in_valid = 1'b0;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            rnd[i] = 0;
            for (int j = 0; j < i; j++) begin
                if (vld[j] && vld[i] && (a[j][1:0] == a[i][1:0])) rnd[i]++;
            end
            if (vld[i] && (rnd[i] + 1 > k)) k = rnd[i] + 1;
        end
        for (int r = 0; r < k; r++) begin
            bt = '0;
            for (int i = 0; i < 4; i++) begin
                if (vld[i] && (rnd[i] == r)) begin
                    bt.we[a[i][1:0]]   = 1'b1;
                    bt.addr[a[i][1:0]] = a[i][15:2];
                    bt.data[a[i][1:0]] = d[i];
                end
            end
            exp_q.push_back(bt);
        end
`ifdef WSCHED_STATS_EN
        if (acc && (k >= 2) && (exp_cnt != 65535)) exp_cnt++;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.lane_vld   = 4'b0000;
        bus.lane_addr0 = '0;
        bus.lane_addr1 = '0;
        bus.lane_addr2 = '0;
        bus.lane_addr3 = '0;
        bus.lane_data0 = '0;
        bus.lane_data1 = '0;
        bus.lane_data2 = '0;
        bus.lane_data3 = '0;

        // Reset state
        #2;
        chk("rst_ready", bus.in_ready, 64'h1);
        chk("rst_busy", bus.busy, 64'h0);
        chk("rst_we", bus.bank_we, 64'h0);
        chk("rst_addr0", bus.bank_addr0, 64'h0);
        chk("rst_data3", bus.bank_data3, 64'h0);
        #10 rst_n = 1'b1;
        step();

        // All four banks distinct: one round
        send(4'hF, 16'h0010, 16'h0021, 16'h0032, 16'h0043,
             32'h11, 32'h22, 32'h33, 32'h44);
        chk("dist_we", bus.bank_we, 64'hF);
        chk("dist_ready", bus.in_ready, 64'h1);
        chk("dist_busy", bus.busy, 64'h0);
        chk("dist_addr0", bus.bank_addr0, 64'h004);
        chk("dist_addr3", bus.bank_addr3, 64'h010);
        step();
        chk("dist_we_after", bus.bank_we, 64'h0);

        // All lanes to bank 2: four rounds
        send(4'hF, 16'h0002, 16'h0006, 16'h000A, 16'h000E,
             32'hA0, 32'hA1, 32'hA2, 32'hA3);
        chk("b2_we_t1", bus.bank_we, 64'h4);
        chk("b2_ready_t1", bus.in_ready, 64'h0);
        chk("b2_busy_t1", bus.busy, 64'h1);
        step();
        chk("b2_ready_t2", bus.in_ready, 64'h0);
        step();
        chk("b2_ready_t3", bus.in_ready, 64'h0);
        chk("b2_we_t3", bus.bank_we, 64'h4);
        step();
        chk("b2_ready_t4", bus.in_ready, 64'h1);
        chk("b2_busy_t4", bus.busy, 64'h0);
        chk("b2_we_t4", bus.bank_we, 64'h4);
        chk("b2_addr_t4", bus.bank_addr2, 64'h003);
        step();
        chk("b2_we_t5", bus.bank_we, 64'h0);
`ifdef WSCHED_STATS_EN
        chk("b2_cnt", conflict_cnt, 64'(exp_cnt));
`endif

        // Same address on lanes 0 and 3: ascending lane order
        send(4'b1001, 16'h0005, 16'h0000, 16'h0000, 16'h0005,
             32'hAAAA, 32'h0, 32'h0, 32'hBBBB);
        chk("same_data_t1", bus.bank_data1, 64'hAAAA);
        step();
        chk("same_we_t2", bus.bank_we, 64'h2);
        chk("same_data_t2", bus.bank_data1, 64'hBBBB);
        step();

        // Two-round group with a three-cycle ena stall
        send(4'b0011, 16'h0000, 16'h0004, 16'h0000, 16'h0000,
             32'h5, 32'h6, 32'h0, 32'h0);
        chk("stall_we_t1", bus.bank_we, 64'h1);
        ena = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            chk("stall_we", bus.bank_we, 64'h0);
            chk("stall_ready", bus.in_ready, 64'h0);
            chk("stall_busy", bus.busy, 64'h1);
        end
        ena = 1'b1;
        step();
        chk("stall_we_resume", bus.bank_we, 64'h1);
        chk("stall_addr_resume", bus.bank_addr0, 64'h001);
        chk("stall_ready_resume", bus.in_ready, 64'h1);
        step();

        // Asynchronous reset after round 1 of a four-round group
        send(4'hF, 16'h0003, 16'h0007, 16'h000B, 16'h000F,
             32'hC0, 32'hC1, 32'hC2, 32'hC3);
        chk("arst_we_t1", bus.bank_we, 64'h8);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", bus.bank_we, 64'h0);
        chk("arst_ready", bus.in_ready, 64'h1);
        chk("arst_busy", bus.busy, 64'h0);
        chk("arst_addr3", bus.bank_addr3, 64'h0);
        chk("arst_data3", bus.bank_data3, 64'h0);
        exp_q.delete();
`ifdef WSCHED_STATS_EN
        exp_cnt = 0;
        chk("arst_cnt", conflict_cnt, 64'h0);
`endif
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            step();
            chk("arst_quiet_we", bus.bank_we, 64'h0);
        end

        // Empty group
        send(4'b0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004,
             32'h1, 32'h2, 32'h3, 32'h4);
        chk("empty_we", bus.bank_we, 64'h0);
        chk("empty_busy", bus.busy, 64'h0);
        chk("empty_ready", bus.in_ready, 64'h1);

        // Back-to-back conflict-free groups, one per cycle
        for (int g = 0; g < 6; g++) begin
            send(4'hF,
                 16'(((g * 4 + 0) << 2) | ((g + 0) % 4)),
                 16'(((g * 4 + 1) << 2) | ((g + 1) % 4)),
                 16'(((g * 4 + 2) << 2) | ((g + 2) % 4)),
                 16'(((g * 4 + 3) << 2) | ((g + 3) % 4)),
                 32'(g * 16 + 1), 32'(g * 16 + 2), 32'(g * 16 + 3), 32'(g * 16 + 4));
            chk("b2b_we", bus.bank_we, 64'hF);
            chk("b2b_ready", bus.in_ready, 64'h1);
        end

        // Random groups over a small address range to provoke conflicts
        for (int g = 0; g < 40; g++) begin
            send(4'($urandom_range(0, 15)),
                 16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)),
                 16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)),
                 $urandom, $urandom, $urandom, $urandom);
        end
        for (int s = 0; s < 6; s++) step();
        chk("drain", 64'(exp_q.size()), 64'h0);
        chk("drain_ready", bus.in_ready, 64'h1);
`ifdef WSCHED_STATS_EN
        chk("final_cnt", conflict_cnt, 64'(exp_cnt));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/write_bank_scheduler.md
WRITE_BANK_SCHEDULER -- requirements
Module: write_bank_scheduler

Interface
REQ-001 Parameters SHALL be: ADDRW, default 16, request address width; WL, default 32, data word width.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port ena, input, 1 bit: global enable; low freezes all state.
REQ-005 Port in_valid, input, 1 bit: a group of four lane requests is presented.
REQ-006 Port in_ready, output, 1 bit: scheduler accepts a group this cycle.
REQ-007 Port lane_vld, input, 4 bits: per-lane request valid, bit i = lane i.
REQ-008 Port lane_addr0..lane_addr3, input, ADDRW each: word address; bits [1:0] select the bank.
REQ-009 Port lane_data0..lane_data3, input, WL each: write data per lane.
REQ-010 Port bank_we, output, 4 bits: registered write strobe, bit b = bank b.
REQ-011 Port bank_addr0..bank_addr3, output, ADDRW-2 each: registered bank-local address, taken from lane address bits [ADDRW-1:2].
REQ-012 Port bank_data0..bank_data3, output, WL each: registered write data.
REQ-013 Port busy, output, 1 bit: high while an accepted group still has unissued lanes.

Function
REQ-014 Handshake: a group SHALL be accepted on a rising edge where in_valid, in_ready and ena are all high; otherwise no input is sampled.
REQ-015 in_ready SHALL equal (state == IDLE); busy SHALL equal (state == ISSUE).
REQ-016 On acceptance, round 1 SHALL be selected from the inputs directly: for each bank, the lowest-index valid lane targeting it is issued; its addr/data are registered and its bank_we bit is set in the next cycle.
REQ-017 Lanes valid but not issued in round 1 SHALL be stored in pending registers (vld, addr, data); state becomes ISSUE if any are pending, else stays IDLE.
REQ-018 In ISSUE with ena high, each cycle SHALL issue, per bank, the lowest-index pending lane targeting that bank, clearing it from pending; state returns to IDLE on the edge where pending becomes empty.
REQ-019 Latency: group accepted at edge T needing k rounds (k = max lanes per bank, 1..4) SHALL drive bank_we in cycles T+1..T+k; in_ready low T+1..T+k-1, high at T+k.
REQ-020 Conflict-free groups SHALL sustain one group per cycle.
REQ-021 Lanes targeting the same bank and same address SHALL be written in ascending lane order, so the highest valid lane's data persists.
REQ-022 bank_we bits for banks with nothing to issue in a cycle SHALL be 0; bank_addr/bank_data for those banks hold their previous values.
REQ-023 A group with lane_vld = 0000 SHALL be accepted, produce no bank_we, and leave state IDLE.
REQ-024 ena low SHALL force bank_we to 0 on the next edge and hold state, pending and in_ready unchanged; issuing resumes where it left off when ena returns high.

Reset
REQ-025 rst_n low SHALL immediately clear bank_we, pending vld, bank_addr*, bank_data*, set state IDLE (in_ready 1, busy 0), regardless of operation in progress; pending lanes are discarded.
REQ-026 The first acceptance after reset release SHALL occur no earlier than the first rising edge with rst_n high.

Configuration
REQ-027 Macro WSCHED_STATS_EN, when defined, SHALL add output conflict_cnt, 16 bits, reset 0, incremented on each accepted group needing k >= 2 rounds, saturating at 16'hFFFF.
REQ-028 Without WSCHED_STATS_EN the port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-029 Addresses 0x0010,0x0021,0x0032,0x0043, all valid -> bank_we=1111 at T+1 with bank_addr0..3 = 0x004,0x008,0x00C,0x010; in_ready stays 1.
REQ-030 All four lanes address bank 2 (0x0002,0x0006,0x000A,0x000E) -> bank_we=0100 in T+1..T+4, bank_addr2 = 0x000,0x001,0x002,0x003; in_ready low T+1..T+3; conflict_cnt=1 if enabled.
REQ-031 Lanes 0 and 3 both write 0x0005 with data 0xAAAA and 0xBBBB -> bank 1 written 0xAAAA at T+1, then 0xBBBB at T+2.
REQ-032 Two-round group, ena low for 3 cycles after T+1 -> bank_we=0 during stall, round 2 appears on first enabled cycle after.
REQ-033 rst_n asserted asynchronously mid-group (after round 1 of 4) -> bank_we=0, in_ready=1 immediately; no further writes from that group.
REQ-034 lane_vld=0000 with in_valid high -> accepted, bank_we stays 0000, busy stays 0.
